// File: rtl/key_debounce_blck.sv
// Per-key synchroniser and debouncer: clean level vector plus one-cycle
// press, release and long-press pulses for each key line.
module key_debounce_blck #(
  parameter int          WD_KEY   = 4,
  parameter logic        MD_PRESS = 1'b0,
  parameter logic [31:0] NB_DEB   = 32'd1_000_000,
  parameter logic [31:0] NB_LONG  = 32'd100_000_000
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic [WD_KEY-1:0] i_key_raw,
  output logic [WD_KEY-1:0] o_key_row,
  output logic [WD_KEY-1:0] o_key_press,
  output logic [WD_KEY-1:0] o_key_release,
  output logic [WD_KEY-1:0] o_key_long
);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  logic [WD_KEY-1:0] r_sync1;
  logic [WD_KEY-1:0] r_sync2;
  state_t            r_state [WD_KEY];
  logic [31:0]       r_cnt   [WD_KEY];
  logic [WD_KEY-1:0] r_long_done;
  logic [WD_KEY-1:0] r_row;
  logic [WD_KEY-1:0] r_press;
  logic [WD_KEY-1:0] r_release;
  logic [WD_KEY-1:0] r_long;

  logic [WD_KEY-1:0] w_p;
  state_t            w_state_nxt [WD_KEY];
  logic [31:0]       w_cnt_nxt   [WD_KEY];
  logic [WD_KEY-1:0] w_long_done_nxt;
  logic [WD_KEY-1:0] w_row_nxt;
  logic [WD_KEY-1:0] w_press_nxt;
  logic [WD_KEY-1:0] w_release_nxt;
  logic [WD_KEY-1:0] w_long_nxt;

  assign w_p = ~(r_sync2 ^ {WD_KEY{MD_PRESS}});

  // Two-flop synchroniser on the raw asynchronous key lines
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= {WD_KEY{~MD_PRESS}};
      r_sync2 <= {WD_KEY{~MD_PRESS}};
    end else begin
      r_sync1 <= i_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-key debounce FSM: next state, counter, flag and output pulses
  always_comb begin
    w_long_done_nxt = r_long_done;
    w_row_nxt       = r_row;
    w_press_nxt     = {WD_KEY{1'b0}};
    w_release_nxt   = {WD_KEY{1'b0}};
    w_long_nxt      = {WD_KEY{1'b0}};
    for (int k = 0; k < WD_KEY; k++) begin
      w_state_nxt[k] = r_state[k];
      w_cnt_nxt[k]   = r_cnt[k];
      case (r_state[k])
        ST_RELEASED: begin
          if (w_p[k]) begin
            w_state_nxt[k] = ST_PRESS_CHK;
            w_cnt_nxt[k]   = 32'd0;
          end else begin
            w_row_nxt[k] = ~MD_PRESS;
          end
        end
        ST_PRESS_CHK: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = ST_RELEASED;
          end else if (r_cnt[k] == NB_DEB - 32'd1) begin
            w_state_nxt[k] = ST_PRESSED;
            w_row_nxt[k]   = MD_PRESS;
            w_press_nxt[k] = 1'b1;
            w_cnt_nxt[k]   = 32'd0;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 32'd1;
          end
        end
        ST_PRESSED: begin
          if (!w_p[k]) begin
            w_state_nxt[k] = ST_RELEASE_CHK;
            w_cnt_nxt[k]   = 32'd0;
          end else if (r_cnt[k] == NB_LONG - 32'd1) begin
            // Counter parks here; long_done keeps the pulse to one per press
            if (!r_long_done[k]) begin
              w_long_nxt[k]      = 1'b1;
              w_long_done_nxt[k] = 1'b1;
            end else begin
              w_long_done_nxt[k] = 1'b1;
            end
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 32'd1;
          end
        end
        ST_RELEASE_CHK: begin
          if (w_p[k]) begin
            w_state_nxt[k] = ST_PRESSED;
            w_cnt_nxt[k]   = 32'd0;
          end else if (r_cnt[k] == NB_DEB - 32'd1) begin
            w_state_nxt[k]     = ST_RELEASED;
            w_row_nxt[k]       = ~MD_PRESS;
            w_release_nxt[k]   = 1'b1;
            w_long_done_nxt[k] = 1'b0;
            w_cnt_nxt[k]       = 32'd0;
          end else begin
            w_cnt_nxt[k] = r_cnt[k] + 32'd1;
          end
        end
        default: begin
          w_state_nxt[k]     = ST_RELEASED;
          w_cnt_nxt[k]       = 32'd0;
          w_row_nxt[k]       = ~MD_PRESS;
          w_long_done_nxt[k] = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered output update
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < WD_KEY; k++) begin
        r_state[k] <= ST_RELEASED;
        r_cnt[k]   <= 32'd0;
      end
      r_long_done <= {WD_KEY{1'b0}};
      r_row       <= {WD_KEY{~MD_PRESS}};
      r_press     <= {WD_KEY{1'b0}};
      r_release   <= {WD_KEY{1'b0}};
      r_long      <= {WD_KEY{1'b0}};
    end else begin
      for (int k = 0; k < WD_KEY; k++) begin
        r_state[k] <= w_state_nxt[k];
        r_cnt[k]   <= w_cnt_nxt[k];
      end
      r_long_done <= w_long_done_nxt;
      r_row       <= w_row_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

  assign o_key_row     = r_row;
  assign o_key_press   = r_press;
  assign o_key_release = r_release;
  assign o_key_long    = r_long;

endmodule

// File: tb/tb_key_debounce_blck.sv
// Bench for key_debounce_blck: run-length reference model checked every cycle
// plus literal expectations at the documented event edges.
module tb_key_debounce_blck;

  localparam int   NB_DEB  = 8;
  localparam int   NB_LONG = 32;
  localparam logic MD      = 1'b0;

  logic       clk;
  logic       rst_n;
  logic [3:0] raw;
  logic [3:0] key_row;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int n_checks;
  int n_errors;

  // model state
  logic [3:0] m_s1, m_s2, m_prev, m_ld;
  logic [3:0] e_row, e_press, e_rel, e_long;
  int         m_run  [4];
  int         m_held [4];

  key_debounce_blck #(
    .WD_KEY  (4),
    .MD_PRESS(1'b0),
    .NB_DEB  (32'd8),
    .NB_LONG (32'd32)
  ) dut (
    .i_sys_clk    (clk),
    .i_rst_n      (rst_n),
    .i_key_raw    (raw),
    .o_key_row    (key_row),
    .o_key_press  (key_press),
    .o_key_release(key_release),
    .o_key_long   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF; m_prev = 4'hF; m_ld = 4'h0;
    e_row = 4'hF; e_press = 4'h0; e_rel = 4'h0; e_long = 4'h0;
    for (int k = 0; k < 4; k++) begin
      m_run[k]  = 0;
      m_held[k] = 0;
    end
  endtask

  // A level is accepted once the synchronised line has disagreed with the
  // accepted level on NB_DEB+1 consecutive edges; long fires NB_LONG edges
  // into an uninterrupted hold.
  task automatic model_step();
    logic s;
    logic ps, acc;
    for (int k = 0; k < 4; k++) begin
      s = m_s2[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = raw[k];
      ps  = (s == MD);
      acc = (e_row[k] == MD);
      e_press[k] = 1'b0;
      e_rel[k]   = 1'b0;
      e_long[k]  = 1'b0;
      if (acc && ps) begin
        if (m_prev[k] != MD) m_held[k] = 0;
        else if (m_held[k] < NB_LONG) m_held[k]++;
        if (m_held[k] == NB_LONG && !m_ld[k]) begin
          e_long[k] = 1'b1;
          m_ld[k]   = 1'b1;
        end
      end
      if (ps != acc) begin
        m_run[k]++;
        if (m_run[k] == NB_DEB + 1) begin
          m_run[k] = 0;
          e_row[k] = ~e_row[k];
          if (ps) begin
            e_press[k] = 1'b1;
            m_held[k]  = 0;
          end else begin
            e_rel[k] = 1'b1;
            m_ld[k]  = 1'b0;
          end
        end
      end else begin
        m_run[k] = 0;
      end
      m_prev[k] = s;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      #1;
      chk("row",     key_row,     e_row);
      chk("press",   key_press,   e_press);
      chk("release", key_release, e_rel);
      chk("long",    key_long,    e_long);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v);
    @(negedge clk);
    raw = v;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    raw   = 4'hF;
    tick(3);
    chk("rst_row", key_row, 4'hF);
    chk("rst_press", key_press, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // clean press on key 0, then release glitch and final release
    drive(4'hE);
    tick(10);
    chk("press0_early_row", key_row, 4'hF);
    chk("press0_early", key_press, 4'h0);
    tick(1);
    chk("press0_row", key_row, 4'hE);
    chk("press0_pulse", key_press, 4'h1);
    tick(1);
    chk("press0_one_cycle", key_press, 4'h0);
    drive(4'hF);
    tick(3);
    drive(4'hE);
    tick(5);
    chk("rel_glitch_row", key_row, 4'hE);
    drive(4'hF);
    tick(10);
    chk("rel0_early", key_release, 4'h0);
    tick(1);
    chk("rel0_pulse", key_release, 4'h1);
    chk("rel0_row", key_row, 4'hF);
    tick(4);

    // bounce on key 1, then a held press
    drive(4'hD); tick(5);
    drive(4'hF); tick(3);
    drive(4'hD); tick(7);
    drive(4'hF); tick(3);
    chk("bounce_row", key_row, 4'hF);
    drive(4'hD);
    tick(10);
    chk("bounce_hold_early", key_row, 4'hF);
    tick(1);
    chk("bounce_hold_row", key_row, 4'hD);
    chk("bounce_hold_press", key_press, 4'h2);
    drive(4'hF);
    tick(15);

    // long press on key 2 with a later release glitch
    drive(4'hB);
    tick(42);
    chk("long_early", key_long, 4'h0);
    tick(1);
    chk("long_pulse", key_long, 4'h4);
    tick(1);
    chk("long_one_cycle", key_long, 4'h0);
    tick(56);
    drive(4'hF); tick(3);
    drive(4'hB);
    for (int i = 0; i < 60; i++) begin
      tick(1);
      chk("long_no_repeat", key_long, 4'h0);
    end
    drive(4'hF);
    tick(15);

    // simultaneous press on keys 0 and 3
    drive(4'h6);
    tick(10);
    chk("simul_early", key_press, 4'h0);
    tick(1);
    chk("simul_press", key_press, 4'h9);
    chk("simul_row", key_row, 4'h6);
    drive(4'hF);
    tick(15);

    // reset during PRESS_CHK, then during PRESSED, key held throughout
    drive(4'hE);
    tick(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_chk_row", key_row, 4'hF);
    chk("rst_chk_press", key_press, 4'h0);
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    chk("rst_held_early", key_row, 4'hF);
    tick(1);
    chk("rst_held_row", key_row, 4'hE);
    chk("rst_held_press", key_press, 4'h1);
    tick(5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pressed_row", key_row, 4'hF);
    chk("rst_pressed_rel", key_release, 4'h0);
    chk("rst_pressed_press", key_press, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(11);
    chk("rst2_press", key_press, 4'h1);
    chk("rst2_row", key_row, 4'hE);
    drive(4'hF);
    tick(15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
